cnn_layer_sequencer: RTL and testbench
======================================

Name: cnn_layer_sequencer

Overview:
- Top-level phase controller for the digit-recognition CNN datapath.
- Steps the six per-layer memory counter/addresser groups in order: image load, conv1, pool1, conv2, pool2, fc. For each phase it issues a clear pulse, holds the counter enable until that counter reports done, then waits a fixed pipeline-drain interval.
- Guards each phase with a watchdog and presents the final result through a valid/ack handshake to the host interface.

Parameters:
NPHASE, 6, number of sequenced phases; phase index 0=img_load, 1=conv1, 2=pool1, 3=conv2, 4=pool2, 5=fc
DRAIN_CYC, 4, idle cycles after a phase's done before the next phase is cleared (MAC/ReLU pipeline flush); legal range 0..15
TIMEOUT, 2048, maximum cycles allowed in RUN for one phase before error; legal range 1..65535

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request to begin a frame; honoured only in IDLE or ERROR
abort  in  1  synchronous abort; highest priority after reset
phase_done  in  NPHASE  done flags from the counter groups, bit i = phase i
phase_clr  out  NPHASE  one-cycle clear pulse to counter group i
phase_en  out  NPHASE  enable to counter group i; at most one bit high
phase_id  out  3  index of the current phase; 0 in IDLE
busy  out  1  high in CLR, RUN and DRAIN
result_valid  out  1  frame complete, result memory stable
result_ack  in  1  host consumed the result
err  out  1  watchdog expired; sticky until start or abort
err_phase  out  3  phase index that timed out; valid while err=1

Behaviour:
- Reset values: state=IDLE, phase_id=0, phase_clr=0, phase_en=0, busy=0, result_valid=0, err=0, err_phase=0, drain and watchdog counters=0.
- States: IDLE, CLR, RUN, DRAIN, FINISH, ERROR. All outputs are registered.
- IDLE:
  - start=1 -> CLR with phase_id=0; err is cleared.
- CLR (1 cycle):
  - phase_clr[phase_id]=1 and phase_en=0.
  - Watchdog loads 0.
  - Next state is RUN.
- RUN:
  - phase_en[phase_id]=1 and the watchdog increments each cycle.
  - phase_done[phase_id]=1 -> DRAIN. phase_en drops on the cycle after done is sampled, so the counter saw enable with done=1 and holds.
  - Done bits of other phases are ignored.
  - Watchdog reaching TIMEOUT-1 with no done -> ERROR: err=1, err_phase=phase_id, phase_en=0.
  - If done and timeout occur in the same cycle, done wins.
- DRAIN:
  - phase_en=0 and the drain counter counts DRAIN_CYC cycles.
  - With DRAIN_CYC=0, DRAIN lasts zero cycles: RUN goes directly to the next CLR, or to FINISH.
  - At expiry: if phase_id<NPHASE-1, phase_id increments and the state goes to CLR; otherwise -> FINISH.
- FINISH:
  - result_valid=1 and busy=0; phase_id holds NPHASE-1.
  - result_ack=1 -> IDLE and result_valid drops the next cycle.
  - start is ignored while result_valid=1.
- ERROR:
  - err=1, all enables are 0, busy=0.
  - start -> CLR with phase_id=0 and err cleared.
- abort=1 in any state:
  - Next cycle: IDLE, phase_en=0, phase_clr all ones for 1 cycle, result_valid=0, err=0.
  - abort beats start and result_ack in the same cycle.
- Asynchronous reset mid-frame: immediate return to reset values. The counters are reset by the same net, so no clear pulse is issued.
- start while busy: ignored (no queuing).
- Invariants:
  - phase_clr and phase_en are never high on the same bit in the same cycle.
  - At most one phase_en bit is high at any time.
- Frame latency:
  - Sum over i of (1 + run_i + DRAIN_CYC) cycles from the cycle start is sampled to result_valid rising.
  - run_i counts cycles from RUN entry through the cycle done is sampled.

Test Plan:
- Nominal frame, DRAIN_CYC=4: each phase_done asserted 10 cycles after its phase_en rises -> phase_clr pulses in order 0..5, each phase gets 10 enable cycles, result_valid rises 6*(1+10+4)=90 cycles after start; result_ack -> IDLE next cycle.
- Watchdog, TIMEOUT=16: never assert phase_done[2] -> err=1 and err_phase=2 after 16 RUN cycles, phase_en=0; a subsequent start restarts at phase 0 with err=0.
- Abort during phase 3 RUN -> next cycle phase_en=0, phase_clr=6'b111111 for one cycle, state IDLE, busy=0; a simultaneous start is ignored.
- Wrong-phase done: assert phase_done[4] during phase 1 RUN -> no transition; phase_done[1] then advances the sequence normally.
- DRAIN_CYC=0 with done on the same cycle as timeout expiry -> advances to the next CLR, no err; start during busy and during FINISH is ignored.
- Asynchronous reset asserted mid-DRAIN between clock edges -> all outputs at reset values immediately; a frame started after reset release completes normally.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// Phase controller for the digit-recognition CNN datapath: clears, enables and drains
// each layer's counter group in turn, with a per-phase watchdog and result handshake.
module cnn_layer_sequencer #(
  parameter int unsigned NPHASE    = 6,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned TIMEOUT   = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [NPHASE-1:0] phase_done,
  output logic [NPHASE-1:0] phase_clr,
  output logic [NPHASE-1:0] phase_en,
  output logic [2:0]        phase_id,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ack,
  output logic              err,
  output logic [2:0]        err_phase
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [2:0]        LAST_PHASE = 3'(NPHASE - 1);
  localparam logic [15:0]       WD_LAST    = 16'(TIMEOUT - 1);
  localparam logic [3:0]        DRAIN_LAST = 4'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);
  localparam logic [NPHASE-1:0] ONE        = NPHASE'(1);

  state_t            state, state_n;
  logic [2:0]        phase_id_n;
  logic [15:0]       wdog, wdog_n;
  logic [3:0]        drain, drain_n;
  logic              err_n;
  logic [2:0]        err_phase_n;
  logic [NPHASE-1:0] clr_n, en_n;
  logic              busy_n, valid_n;
  logic              advance;

  always_comb begin
    state_n     = state;
    phase_id_n  = phase_id;
    wdog_n      = wdog;
    drain_n     = drain;
    err_n       = err;
    err_phase_n = err_phase;
    advance     = 1'b0;

    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_n     = S_CLR;
          phase_id_n  = '0;
          err_n       = 1'b0;
          err_phase_n = '0;
        end
      end
      S_CLR: begin
        state_n = S_RUN;
        wdog_n  = '0;
      end
      S_RUN: begin
        // done takes precedence over a watchdog expiring in the same cycle
        if (phase_done[phase_id]) begin
          if (DRAIN_CYC == 0) begin
            advance = 1'b1;
          end else begin
            state_n = S_DRAIN;
            drain_n = '0;
          end
        end else if (wdog == WD_LAST) begin
          state_n     = S_ERROR;
          err_n       = 1'b1;
          err_phase_n = phase_id;
        end else begin
          wdog_n = wdog + 16'd1;
        end
      end
      S_DRAIN: begin
        if (drain == DRAIN_LAST) advance = 1'b1;
        else                     drain_n = drain + 4'd1;
      end
      S_FINISH: begin
        if (result_ack) begin
          state_n    = S_IDLE;
          phase_id_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // shared by RUN (zero-length drain) and DRAIN expiry
    if (advance) begin
      if (phase_id == LAST_PHASE) begin
        state_n = S_FINISH;
      end else begin
        state_n    = S_CLR;
        phase_id_n = phase_id + 3'd1;
      end
    end

    if (abort) begin
      state_n     = S_IDLE;
      phase_id_n  = '0;
      wdog_n      = '0;
      drain_n     = '0;
      err_n       = 1'b0;
      err_phase_n = '0;
    end

    // outputs are decoded from the next state so they register alongside it
    clr_n   = abort ? '1 : ((state_n == S_CLR) ? (ONE << phase_id_n) : '0);
    en_n    = (state_n == S_RUN) ? (ONE << phase_id_n) : '0;
    busy_n  = (state_n == S_CLR) || (state_n == S_RUN) || (state_n == S_DRAIN);
    valid_n = (state_n == S_FINISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      phase_id     <= '0;
      wdog         <= '0;
      drain        <= '0;
      err          <= 1'b0;
      err_phase    <= '0;
      phase_clr    <= '0;
      phase_en     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      phase_id     <= phase_id_n;
      wdog         <= wdog_n;
      drain        <= drain_n;
      err          <= err_n;
      err_phase    <= err_phase_n;
      phase_clr    <= clr_n;
      phase_en     <= en_n;
      busy         <= busy_n;
      result_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: instance a uses DRAIN_CYC=4, instance b uses
// DRAIN_CYC=0; both use TIMEOUT=16. Inputs driven and outputs sampled on negedge.
module tb_cnn_layer_sequencer;

  logic       clk;
  logic       reset;
  logic       start_a, abort_a, ack_a;
  logic [5:0] done_a, clr_a, en_a;
  logic [2:0] id_a, ep_a;
  logic       busy_a, rv_a, err_a;
  logic       start_b, abort_b, ack_b;
  logic [5:0] done_b, clr_b, en_b;
  logic [2:0] id_b, ep_b;
  logic       busy_b, rv_b, err_b;

  int checks = 0;
  int errors = 0;

  cnn_layer_sequencer #(.NPHASE(6), .DRAIN_CYC(4), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .phase_done(done_a),
    .phase_clr(clr_a), .phase_en(en_a), .phase_id(id_a), .busy(busy_a),
    .result_valid(rv_a), .result_ack(ack_a), .err(err_a), .err_phase(ep_a)
  );

  cnn_layer_sequencer #(.NPHASE(6), .DRAIN_CYC(0), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .phase_done(done_b),
    .phase_clr(clr_b), .phase_en(en_b), .phase_id(id_b), .busy(busy_b),
    .result_valid(rv_b), .result_ack(ack_b), .err(err_b), .err_phase(ep_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] oh(input int p);
    oh = 6'b000001 << p;
  endfunction

  // Stimulus only: from the CLR cycle of phase p, walk RUN (done on cycle run) and
  // the 4 drain cycles of instance a, ending on the next phase's CLR (or FINISH).
  task automatic walk_phase_a(input int p, input int run);
    repeat (run) @(negedge clk);
    done_a = oh(p);
    @(negedge clk);
    done_a = '0;
    repeat (3) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({clr_a, en_a, id_a, busy_a, rv_a, err_a, ep_a} !== 24'h0) begin
      errors++;
      $display("FAIL reset_a got=%h exp=%h", {clr_a, en_a, id_a, busy_a, rv_a, err_a, ep_a}, 24'h0);
    end
    checks++;
    if ({clr_b, en_b, id_b, busy_b, rv_b, err_b, ep_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_b got=%h exp=%h", {clr_b, en_b, id_b, busy_b, rv_b, err_b, ep_b}, 24'h0);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({clr_a, en_a, busy_a, rv_a} !== 14'h0) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=%h", {clr_a, en_a, busy_a, rv_a}, 14'h0);
    end
  endtask

  task automatic test_nominal();
    logic [16:0] exp;
    int p, off;
    start_a = 1'b1;
    for (int n = 1; n <= 91; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      done_a  = '0;
      if (n <= 90) begin
        p   = (n - 1) / 15;
        off = (n - 1) % 15;
        exp = {(off == 0) ? oh(p) : 6'b0, (off >= 1 && off <= 10) ? oh(p) : 6'b0, 3'(p), 1'b1, 1'b0};
        if (off == 10) done_a = oh(p);
      end else begin
        exp = {6'b0, 6'b0, 3'd5, 1'b0, 1'b1};
      end
      checks++;
      if ({clr_a, en_a, id_a, busy_a, rv_a} !== exp) begin
        errors++;
        $display("FAIL nominal_n%0d got=%h exp=%h", n, {clr_a, en_a, id_a, busy_a, rv_a}, exp);
      end
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if ({clr_a, en_a, id_a, busy_a, rv_a} !== {6'b0, 6'b0, 3'd5, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL finish_start_ignored got=%h exp=%h", {clr_a, en_a, id_a, busy_a, rv_a},
               {6'b0, 6'b0, 3'd5, 1'b0, 1'b1});
    end
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    checks++;
    if ({clr_a, en_a, id_a, busy_a, rv_a} !== 17'h0) begin
      errors++;
      $display("FAIL ack_idle got=%h exp=%h", {clr_a, en_a, id_a, busy_a, rv_a}, 17'h0);
    end
  endtask

  task automatic test_watchdog();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    walk_phase_a(0, 3);
    walk_phase_a(1, 3);
    checks++;
    if ({clr_a, id_a} !== {oh(2), 3'd2}) begin
      errors++;
      $display("FAIL wd_clr2 got=%h exp=%h", {clr_a, id_a}, {oh(2), 3'd2});
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if ({en_a, err_a} !== {oh(2), 1'b0}) begin
        errors++;
        $display("FAIL wd_run_k%0d got=%h exp=%h", k, {en_a, err_a}, {oh(2), 1'b0});
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({clr_a, en_a, busy_a, err_a, ep_a} !== {6'b0, 6'b0, 1'b0, 1'b1, 3'd2}) begin
        errors++;
        $display("FAIL wd_err_%0d got=%h exp=%h", k, {clr_a, en_a, busy_a, err_a, ep_a},
                 {6'b0, 6'b0, 1'b0, 1'b1, 3'd2});
      end
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if ({clr_a, id_a, err_a, busy_a} !== {oh(0), 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL wd_restart got=%h exp=%h", {clr_a, id_a, err_a, busy_a}, {oh(0), 3'd0, 1'b0, 1'b1});
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int p = 0; p < 3; p++) walk_phase_a(p, 2);
    repeat (3) @(negedge clk);
    checks++;
    if ({en_a, id_a} !== {oh(3), 3'd3}) begin
      errors++;
      $display("FAIL abort_pre got=%h exp=%h", {en_a, id_a}, {oh(3), 3'd3});
    end
    abort_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    start_a = 1'b0;
    checks++;
    if ({clr_a, en_a, id_a, busy_a, rv_a, err_a} !== {6'h3f, 6'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_clr got=%h exp=%h", {clr_a, en_a, id_a, busy_a, rv_a, err_a},
               {6'h3f, 6'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({clr_a, en_a, busy_a} !== 13'h0) begin
      errors++;
      $display("FAIL abort_idle got=%h exp=%h", {clr_a, en_a, busy_a}, 13'h0);
    end
  endtask

  task automatic test_wrong_phase();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    walk_phase_a(0, 2);
    @(negedge clk);
    done_a = 6'b010000;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({en_a, id_a, busy_a} !== {oh(1), 3'd1, 1'b1}) begin
        errors++;
        $display("FAIL wrong_done_k%0d got=%h exp=%h", k, {en_a, id_a, busy_a}, {oh(1), 3'd1, 1'b1});
      end
    end
    done_a = oh(1);
    @(negedge clk);
    done_a = '0;
    checks++;
    if ({clr_a, en_a, id_a, busy_a} !== {6'b0, 6'b0, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL right_done_drain got=%h exp=%h", {clr_a, en_a, id_a, busy_a}, {6'b0, 6'b0, 3'd1, 1'b1});
    end
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if ({clr_a, en_a, id_a} !== {oh(2), 6'b0, 3'd2}) begin
      errors++;
      $display("FAIL right_done_next got=%h exp=%h", {clr_a, en_a, id_a}, {oh(2), 6'b0, 3'd2});
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drain_zero();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    checks++;
    if ({clr_b, busy_b} !== {oh(0), 1'b1}) begin
      errors++;
      $display("FAIL d0_clr0 got=%h exp=%h", {clr_b, busy_b}, {oh(0), 1'b1});
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if ({clr_b, en_b, id_b, err_b} !== {6'b0, oh(0), 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL d0_run_k%0d got=%h exp=%h", k, {clr_b, en_b, id_b, err_b}, {6'b0, oh(0), 3'd0, 1'b0});
      end
      start_b = (k == 5);
      if (k == 16) done_b = oh(0);
    end
    @(negedge clk);
    done_b  = '0;
    start_b = 1'b0;
    checks++;
    if ({clr_b, en_b, id_b, busy_b, err_b} !== {oh(1), 6'b0, 3'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL d0_done_wins got=%h exp=%h", {clr_b, en_b, id_b, busy_b, err_b},
               {oh(1), 6'b0, 3'd1, 1'b1, 1'b0});
    end
    for (int p = 1; p <= 5; p++) begin
      @(negedge clk);
      done_b = oh(p);
      @(negedge clk);
      done_b = '0;
      checks++;
      if (p < 5) begin
        if ({clr_b, id_b, busy_b, rv_b} !== {oh(p + 1), 3'(p + 1), 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL d0_clr%0d got=%h exp=%h", p + 1, {clr_b, id_b, busy_b, rv_b},
                   {oh(p + 1), 3'(p + 1), 1'b1, 1'b0});
        end
      end else if ({clr_b, en_b, id_b, busy_b, rv_b} !== {6'b0, 6'b0, 3'd5, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL d0_finish got=%h exp=%h", {clr_b, en_b, id_b, busy_b, rv_b},
                 {6'b0, 6'b0, 3'd5, 1'b0, 1'b1});
      end
    end
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    checks++;
    if ({clr_b, busy_b, rv_b} !== {6'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL d0_finish_start got=%h exp=%h", {clr_b, busy_b, rv_b}, {6'b0, 1'b0, 1'b1});
    end
    ack_b = 1'b1;
    @(negedge clk);
    ack_b = 1'b0;
    checks++;
    if ({rv_b, busy_b, id_b} !== 5'h0) begin
      errors++;
      $display("FAIL d0_ack got=%h exp=%h", {rv_b, busy_b, id_b}, 5'h0);
    end
  endtask

  task automatic test_async_reset();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    done_a = oh(0);
    @(negedge clk);
    done_a = '0;
    @(negedge clk);
    checks++;
    if ({en_a, busy_a} !== {6'b0, 1'b1}) begin
      errors++;
      $display("FAIL ar_in_drain got=%h exp=%h", {en_a, busy_a}, {6'b0, 1'b1});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({clr_a, en_a, id_a, busy_a, rv_a, err_a, ep_a} !== 24'h0) begin
      errors++;
      $display("FAIL ar_immediate got=%h exp=%h", {clr_a, en_a, id_a, busy_a, rv_a, err_a, ep_a}, 24'h0);
    end
    @(negedge clk);
    reset   = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      done_a  = '0;
      if (n <= 36 && (n - 1) % 6 == 1) done_a = oh((n - 1) / 6);
      checks++;
      if ({busy_a, rv_a} !== {(n <= 36), (n == 37)}) begin
        errors++;
        $display("FAIL ar_frame_n%0d got=%b exp=%b", n, {busy_a, rv_a}, {(n <= 36), (n == 37)});
      end
    end
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; ack_a = 1'b0; done_a = '0;
    start_b = 1'b0; abort_b = 1'b0; ack_b = 1'b0; done_b = '0;
    test_reset();
    test_nominal();
    test_watchdog();
    test_abort();
    test_wrong_phase();
    test_drain_zero();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
